microc_stack: RTL and testbench
===============================

# microc_stack

Parametrised single-cycle 8-bit microcontroller datapath, successor to the current `microc`. It adds three things the current datapath lacks:
- a hardware return stack for subroutine call/return, with configurable depth;
- a carry flag beside the zero flag;
- an external instruction-memory port, so program storage lives outside the block.

It is driven by the existing control unit, extended with `s_call`, `s_ret` and `wec`, and executes one instruction per clock.

## Interface
Parameters:
- `STACK_DEPTH`, 8, return-stack entries; power of two, ≥2
- `RESET_PC`, 10'd0, PC value loaded on reset

Ports (clock and reset first):
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `instr`  in  16  instruction word read from external program memory at `instr_addr`
- `s_inc`  in  1  1: PC ← `instr[9:0]` (jump)
- `s_inm`  in  1  immediate-operand select
- `we`  in  1  register-file write enable
- `wez`  in  1  zero-flag write enable
- `wec`  in  1  carry-flag write enable
- `s_call`  in  1  push PC+1, then jump to `instr[9:0]`
- `s_ret`  in  1  pop PC from stack
- `ALUOp`  in  3  ALU function
- `instr_addr`  out  10  current PC
- `Opcode`  out  6  `instr[15:10]`
- `zero`  out  1  registered zero flag
- `carry`  out  1  registered carry flag
- `sp`  out  log2(STACK_DEPTH)+1  entries currently on the stack
- `stack_ovf`  out  1  sticky: call was issued while the stack was full
- `stack_unf`  out  1  sticky: return was issued while the stack was empty

## Operation
Instruction fields:
- `RA1` = `instr[11:8]`
- `RA2` = `instr[7:4]`
- `WA3` = `instr[3:0]`
- `imm` = `instr[11:4]`
- `jump` = `instr[9:0]`

Datapath:
- Operand A: read port 1 addresses `WA3` when `s_inm`=1, otherwise `RA1`.
- Operand B: `imm` when `s_inm`=1, otherwise register `RA2`.
- Register file: 16×8.
  - Reads are combinational.
  - Writes `WD3` to `WA3` on the clock edge when `we`=1.
  - R0 always reads 0; writes to R0 are discarded.

ALU (9-bit internal result):

| `ALUOp` | Result | Carry |
|---|---|---|
| 000 | A | 0 |
| 001 | ~A | 0 |
| 010 | A+B | bit 8 of the sum |
| 011 | A−B | 1 when A<B (unsigned borrow) |
| 100 | A&B | 0 |
| 101 | A\|B | 0 |
| 110 | −A | 0 |
| 111 | −B | 0 |

Flags:
- `zero` ← (result[7:0]==0) when `wez`=1.
- `carry` ← ALU carry when `wec`=1.

Next-PC priority, highest first:
1. `s_ret`:
   - Stack non-empty: PC ← top entry, `sp` decrements.
   - Stack empty: PC ← PC+1, `stack_unf` is set, `sp` unchanged.
2. `s_call`:
   - Stack not full: push PC+1, PC ← `jump`.
   - Stack full: jump is still taken, stack is unchanged, `stack_ovf` is set.
3. `s_inc`: PC ← `jump`.
4. Otherwise PC ← PC+1.

Other PC and stack rules:
- `s_ret` together with `s_call` is a control-unit error: the return is executed and the call is ignored.
- The PC wraps 10'h3FF → 10'h000.
- Pushed return addresses wrap the same way (call at 10'h3FF pushes 10'h000).
- Register, flag and stack updates in the same cycle are independent; a call instruction may also write a register.

## Timing
- Single cycle: `instr` must be valid combinationally from `instr_addr` within the same cycle.
- All state updates on the rising edge of `clk`: PC, register file, stack, `sp`, flags, sticky bits.
- `Opcode` is combinational from `instr`; flags are visible the cycle after the write.
- Reset (asynchronous, at any point in execution):
  - PC ← `RESET_PC`
  - registers ← 0
  - `zero`, `carry` ← 0
  - `sp` ← 0
  - `stack_ovf`, `stack_unf` ← 0
  - stack contents are don't-care
- Sticky bits clear only on reset.

## Structure
- Shared include `microc_defs.vh`: ALU opcode localparams (`ALU_PASSA`…`ALU_NEGB`), field bit positions, PC width 10, data width 8.
- One sub-module, `ret_stack`, parameterised by `STACK_DEPTH` and width 10.
  - Holds the LIFO array and pointer.
  - Provides push/pop, full/empty and the sticky error bits.
- Reuse existing `registro`, `mux2`, `sum`, `ffd` for PC, muxes, incrementer and flags. The ALU is new: the 8-bit ALU with carry.

## Test plan
- Reset mid-run:
  - Stimulus: run the PC to 5, assert `reset` asynchronously.
  - Required response: `instr_addr`=0 immediately; `zero`, `carry`, `sp`, sticky bits all 0.
- Add with carry:
  - Stimulus: R1=8'hF0, R2=8'h20; `ALUOp`=010, `we`/`wez`/`wec` set, `WA3`=3.
  - Required response: R3=8'h10, `carry`=1, `zero`=0.
- Immediate path:
  - Stimulus: R4=8'h05, `s_inm`=1, `imm`=8'h05, `ALUOp`=011, `wez`.
  - Required response: R4=0, `zero`=1, `carry`=0.
- Call/return:
  - Stimulus: call at PC=10'h010 to 10'h100, then `s_ret` at 10'h102.
  - Required response: `sp` 0→1→0; PC sequence 010, 100, 101, 102, 011.
- Stack overflow and underflow (`STACK_DEPTH`=8):
  - Stimulus: 9 nested calls, then 10 returns.
  - Required response: 9th call jumps with `sp`=8 and `stack_ovf`=1; 8 returns unwind correctly; the 9th return gives PC+1 and `stack_unf`=1.
- R0 and simultaneous controls:
  - Stimulus: write 8'hAA to R0; then assert `s_call` and `s_ret` in the same cycle.
  - Required response: R0 reads 0; only the return executes.

Source files
------------

// File: rtl/microc_stack_pkg.sv
// microc_stack_pkg: shared definitions for the microc_stack datapath.
//   - datapath / PC widths
//   - ALU operation encodings (ALU_PASSA .. ALU_NEGB)
//   - instruction field bit positions
//   - alu_exec(): 8-bit ALU with a carry/borrow bit, returned as {carry, result}
package microc_stack_pkg;

    localparam int PC_W   = 10;
    localparam int DATA_W = 8;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_NOTA  = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_NEGA  = 3'b110;
    localparam logic [2:0] ALU_NEGB  = 3'b111;

    // Instruction field LSB positions (imm and RA1/RA2 overlap by design).
    localparam int OPC_LSB = 10;
    localparam int RA1_LSB = 8;
    localparam int RA2_LSB = 4;
    localparam int WA3_LSB = 0;
    localparam int IMM_LSB = 4;
    localparam int JMP_LSB = 0;

    // Bit 8 of the return value is the carry: adder carry-out for ADD,
    // unsigned borrow (A<B) for SUB, zero for everything else.
    function automatic logic [DATA_W:0] alu_exec(input logic [2:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W:0] r;
        r = '0;
        case (op)
            ALU_PASSA: r = {1'b0, a};
            ALU_NOTA:  r = {1'b0, ~a};
            ALU_ADD:   r = {1'b0, a} + {1'b0, b};
            ALU_SUB:   r = {(a < b), a - b};
            ALU_AND:   r = {1'b0, a & b};
            ALU_OR:    r = {1'b0, a | b};
            ALU_NEGA:  r = {1'b0, ~a + 8'd1};
            ALU_NEGB:  r = {1'b0, ~b + 8'd1};
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/microc_stack_ret_stack.sv
// ret_stack: LIFO of return addresses for call/return.
//   clk, reset : clock, async active-high reset (clears pointer and error bits)
//   push, pop  : push din / pop top; pop wins if both are asserted
//   din        : address to push
//   top        : current top-of-stack entry (valid only when !empty)
//   sp         : number of entries held (0..DEPTH)
//   empty      : no entries
//   ovf, unf   : sticky push-while-full / pop-while-empty
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  sp_m1;
    logic         full;
    logic         do_push;
    logic         do_pop;

    assign full    = (sp == FULL_CNT);
    assign empty   = (sp == '0);
    assign sp_m1   = sp - ONE;
    assign top     = mem[sp_m1[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;

    // Contents need no reset: nothing reads them until a push lands.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[sp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (do_pop)
                sp <= sp_m1;
            else if (do_push)
                sp <= sp + ONE;
            if (pop && empty)
                unf <= 1'b1;
            if (push && !pop && full)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/microc_stack.sv
// microc_stack: single-cycle 8-bit datapath with return stack and carry flag.
//   clk, reset          : clock, async active-high reset
//   instr               : instruction word from external memory at instr_addr
//   s_inc/s_call/s_ret  : jump / call / return (return > call > jump > PC+1)
//   s_inm               : immediate operand select (A reads WA3, B = imm)
//   we, wez, wec        : register / zero-flag / carry-flag write enables
//   ALUOp               : ALU function
//   instr_addr, Opcode  : current PC, instr[15:10]
//   zero, carry         : registered flags
//   sp, stack_ovf/unf   : stack depth and sticky stack errors
module microc_stack
    import microc_stack_pkg::*;
#(
    parameter int         STACK_DEPTH = 8,
    parameter logic [9:0] RESET_PC    = 10'd0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  instr,
    input  logic                         s_inc,
    input  logic                         s_inm,
    input  logic                         we,
    input  logic                         wez,
    input  logic                         wec,
    input  logic                         s_call,
    input  logic                         s_ret,
    input  logic [2:0]                   ALUOp,
    output logic [9:0]                   instr_addr,
    output logic [5:0]                   Opcode,
    output logic                         zero,
    output logic                         carry,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                         stack_ovf,
    output logic                         stack_unf
);
    logic [PC_W-1:0]   pc, pc_inc, pc_next, jump, stk_top;
    logic [3:0]        ra1, ra2, wa3, rd1_addr;
    logic [DATA_W-1:0] imm, op_a, op_b, rd2;
    logic [DATA_W:0]   alu_res;
    logic [DATA_W-1:0] rf [16];
    logic              stk_empty;

    assign ra1    = instr[RA1_LSB +: 4];
    assign ra2    = instr[RA2_LSB +: 4];
    assign wa3    = instr[WA3_LSB +: 4];
    assign imm    = instr[IMM_LSB +: DATA_W];
    assign jump   = instr[JMP_LSB +: PC_W];
    assign Opcode = instr[OPC_LSB +: 6];

    assign instr_addr = pc;
    assign pc_inc     = pc + 10'd1;   // natural wrap 3FF -> 000

    // R0 is hard-wired to zero on both read ports.
    assign rd1_addr = s_inm ? wa3 : ra1;
    assign op_a     = (rd1_addr == 4'd0) ? '0 : rf[rd1_addr];
    assign rd2      = (ra2 == 4'd0) ? '0 : rf[ra2];
    assign op_b     = s_inm ? imm : rd2;
    assign alu_res  = alu_exec(ALUOp, op_a, op_b);

    ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (s_call),
        .pop   (s_ret),
        .din   (pc_inc),
        .top   (stk_top),
        .sp    (sp),
        .empty (stk_empty),
        .ovf   (stack_ovf),
        .unf   (stack_unf)
    );

    // A return on an empty stack degrades to a plain PC+1.
    always_comb begin
        pc_next = pc_inc;
        if (s_ret)
            pc_next = stk_empty ? pc_inc : stk_top;
        else if (s_call || s_inc)
            pc_next = jump;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            zero  <= 1'b0;
            carry <= 1'b0;
            for (int i = 0; i < 16; i++)
                rf[i] <= '0;
        end else begin
            pc <= pc_next;
            if (wez)
                zero <= (alu_res[DATA_W-1:0] == '0);
            if (wec)
                carry <= alu_res[DATA_W];
            if (we && wa3 != 4'd0)
                rf[wa3] <= alu_res[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_microc_stack.sv
module tb_microc_stack;
    import microc_stack_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr;
    logic        s_inc, s_inm, we, wez, wec, s_call, s_ret;
    logic [2:0]  ALUOp;
    logic [9:0]  instr_addr;
    logic [5:0]  Opcode;
    logic        zero, carry, stack_ovf, stack_unf;
    logic [3:0]  sp;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] C_INC  = 7'h01;
    localparam logic [6:0] C_INM  = 7'h02;
    localparam logic [6:0] C_WE   = 7'h04;
    localparam logic [6:0] C_WEZ  = 7'h08;
    localparam logic [6:0] C_WEC  = 7'h10;
    localparam logic [6:0] C_CALL = 7'h20;
    localparam logic [6:0] C_RET  = 7'h40;

    microc_stack #(.STACK_DEPTH(8), .RESET_PC(10'd0)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez), .wec(wec),
        .s_call(s_call), .s_ret(s_ret), .ALUOp(ALUOp),
        .instr_addr(instr_addr), .Opcode(Opcode), .zero(zero), .carry(carry),
        .sp(sp), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] i, input logic [2:0] op, input logic [6:0] c);
        instr = i;
        ALUOp = op;
        {s_ret, s_call, wec, wez, we, s_inm, s_inc} = c;
    endtask

    // One instruction: drive, clock, sample 1 ns after the edge, back to NOP.
    task automatic cyc(input logic [15:0] i, input logic [2:0] op, input logic [6:0] c);
        drive(i, op, c);
        @(posedge clk);
        #1;
        drive(16'h0000, ALU_PASSA, 7'h00);
    endtask

    function automatic logic [15:0] fi(input logic [7:0] im, input logic [3:0] wa);
        return {4'h0, im, wa};
    endfunction
    function automatic logic [15:0] fr(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wa);
        return {4'h0, a1, a2, wa};
    endfunction
    function automatic logic [15:0] fj(input logic [9:0] j);
        return {6'h00, j};
    endfunction

    // Register value observed through the zero flag: R[r] - v == 0.
    task automatic check_reg(input logic [3:0] r, input logic [7:0] v, input string tag);
        cyc(fi(v, r), ALU_SUB, C_INM | C_WEZ);
        chk(tag, {15'h0, zero}, 16'h1);
    endtask

    initial begin
        drive(16'h0000, ALU_PASSA, 7'h00);
        #2;
        chk("rst_pc", {6'h0, instr_addr}, 16'h000);
        chk("rst_zero", {15'h0, zero}, 16'h0);
        chk("rst_carry", {15'h0, carry}, 16'h0);
        chk("rst_sp", {12'h0, sp}, 16'h0);
        chk("rst_ovf", {15'h0, stack_ovf}, 16'h0);
        chk("rst_unf", {15'h0, stack_unf}, 16'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Run to PC=5 leaving state behind: R5=FF, unf, a push, carry.
        cyc(16'h0000, ALU_PASSA, 7'h00);
        cyc(16'h0000, ALU_PASSA, 7'h00);
        cyc(fi(8'h01, 4'h5), ALU_NEGB, C_INM | C_WE);
        cyc(16'h0000, ALU_PASSA, C_RET);
        // call to 5 with A=R5=FF + imm 40 -> carry out
        cyc(16'h0405, ALU_ADD, C_CALL | C_INM | C_WEC | C_WEZ);
        chk("run_pc5", {6'h0, instr_addr}, 16'h005);
        chk("run_sp", {12'h0, sp}, 16'h1);
        chk("run_carry", {15'h0, carry}, 16'h1);
        chk("run_unf", {15'h0, stack_unf}, 16'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_pc", {6'h0, instr_addr}, 16'h000);
        chk("arst_carry", {15'h0, carry}, 16'h0);
        chk("arst_zero", {15'h0, zero}, 16'h0);
        chk("arst_sp", {12'h0, sp}, 16'h0);
        chk("arst_unf", {15'h0, stack_unf}, 16'h0);
        #1 reset = 1'b0;
        check_reg(4'h5, 8'h00, "arst_r5");

        // Opcode is instr[15:10]
        drive(16'hFC00, ALU_PASSA, 7'h00);
        #1;
        chk("opcode", {10'h0, Opcode}, 16'h003F);

        // Add with carry: F0 + 20 = 110
        cyc(fi(8'h10, 4'h1), ALU_NEGB, C_INM | C_WE);
        cyc(fi(8'hE0, 4'h2), ALU_NEGB, C_INM | C_WE);
        cyc(fr(4'h1, 4'h2, 4'h3), ALU_ADD, C_WE | C_WEZ | C_WEC);
        chk("add_carry", {15'h0, carry}, 16'h1);
        chk("add_zero", {15'h0, zero}, 16'h0);
        check_reg(4'h3, 8'h10, "add_r3");
        check_reg(4'h1, 8'hF0, "load_r1");

        // Immediate subtract to zero, then borrow
        cyc(fi(8'hFB, 4'h4), ALU_NEGB, C_INM | C_WE);
        cyc(fi(8'h05, 4'h4), ALU_SUB, C_INM | C_WE | C_WEZ | C_WEC);
        chk("imm_zero", {15'h0, zero}, 16'h1);
        chk("imm_carry", {15'h0, carry}, 16'h0);
        check_reg(4'h4, 8'h00, "imm_r4");
        cyc(fi(8'h01, 4'h4), ALU_SUB, C_INM | C_WEC);
        chk("borrow", {15'h0, carry}, 16'h1);
        chk("zero_hold", {15'h0, zero}, 16'h1);

        // Remaining ALU ops on R1=F0, R2=20
        cyc(fr(4'h1, 4'h2, 4'hA), ALU_PASSA, C_WE | C_WEC);
        chk("pass_carry", {15'h0, carry}, 16'h0);
        check_reg(4'hA, 8'hF0, "pass_r10");
        cyc(fr(4'h1, 4'h2, 4'h6), ALU_AND, C_WE);
        check_reg(4'h6, 8'h20, "and_r6");
        cyc(fr(4'h1, 4'h2, 4'h7), ALU_OR, C_WE);
        check_reg(4'h7, 8'hF0, "or_r7");
        cyc(fr(4'h1, 4'h2, 4'h8), ALU_NOTA, C_WE);
        check_reg(4'h8, 8'h0F, "not_r8");
        cyc(fr(4'h2, 4'h1, 4'h9), ALU_NEGA, C_WE);
        check_reg(4'h9, 8'hE0, "nega_r9");

        // Call / return
        cyc(fj(10'h010), ALU_PASSA, C_INC);
        chk("cr_pc010", {6'h0, instr_addr}, 16'h010);
        cyc(fj(10'h100), ALU_PASSA, C_CALL);
        chk("cr_pc100", {6'h0, instr_addr}, 16'h100);
        chk("cr_sp1", {12'h0, sp}, 16'h1);
        cyc(16'h0000, ALU_PASSA, 7'h00);
        chk("cr_pc101", {6'h0, instr_addr}, 16'h101);
        cyc(16'h0000, ALU_PASSA, 7'h00);
        chk("cr_pc102", {6'h0, instr_addr}, 16'h102);
        cyc(16'h0000, ALU_PASSA, C_RET);
        chk("cr_pc011", {6'h0, instr_addr}, 16'h011);
        chk("cr_sp0", {12'h0, sp}, 16'h0);

        // Overflow: 9 nested calls from 0x200, targets 0x210, 0x220, ...
        cyc(fj(10'h200), ALU_PASSA, C_INC);
        for (int i = 0; i < 9; i++) begin
            logic [9:0] tgt;
            tgt = 10'h210 + 10'(i * 16);
            cyc(fj(tgt), ALU_PASSA, C_CALL);
            chk($sformatf("ovf_pc%0d", i), {6'h0, instr_addr}, {6'h0, tgt});
            chk($sformatf("ovf_sp%0d", i), {12'h0, sp}, (i < 8) ? 16'(i + 1) : 16'h8);
            chk($sformatf("ovf_flag%0d", i), {15'h0, stack_ovf}, (i == 8) ? 16'h1 : 16'h0);
        end
        for (int j = 0; j < 8; j++) begin
            cyc(16'h0000, ALU_PASSA, C_RET);
            chk($sformatf("ret_pc%0d", j), {6'h0, instr_addr}, 16'h201 + 16'((7 - j) * 16));
            chk($sformatf("ret_sp%0d", j), {12'h0, sp}, 16'(7 - j));
        end
        chk("unf_before", {15'h0, stack_unf}, 16'h0);
        cyc(16'h0000, ALU_PASSA, C_RET);
        chk("unf_pc", {6'h0, instr_addr}, 16'h202);
        chk("unf_flag", {15'h0, stack_unf}, 16'h1);
        chk("unf_sp", {12'h0, sp}, 16'h0);
        cyc(16'h0000, ALU_PASSA, C_RET);
        chk("unf_pc2", {6'h0, instr_addr}, 16'h203);

        // Wrap of PC and of pushed return address
        cyc(fj(10'h3FF), ALU_PASSA, C_INC);
        cyc(fj(10'h050), ALU_PASSA, C_CALL);
        chk("wrap_call", {6'h0, instr_addr}, 16'h050);
        cyc(16'h0000, ALU_PASSA, C_RET);
        chk("wrap_ret", {6'h0, instr_addr}, 16'h000);
        cyc(fj(10'h3FF), ALU_PASSA, C_INC);
        cyc(16'h0000, ALU_PASSA, 7'h00);
        chk("wrap_pc", {6'h0, instr_addr}, 16'h000);

        // R0 discards writes
        cyc(fi(8'h56, 4'h0), ALU_NEGB, C_INM | C_WE);
        check_reg(4'h0, 8'h00, "r0_zero");

        // Call + return together: only the return happens
        cyc(fj(10'h120), ALU_PASSA, C_INC);
        cyc(fj(10'h300), ALU_PASSA, C_CALL);
        chk("both_pre_pc", {6'h0, instr_addr}, 16'h300);
        cyc(fj(10'h3A0), ALU_PASSA, C_CALL | C_RET);
        chk("both_pc", {6'h0, instr_addr}, 16'h121);
        chk("both_sp", {12'h0, sp}, 16'h0);
        cyc(16'h0000, ALU_PASSA, 7'h00);
        chk("both_next", {6'h0, instr_addr}, 16'h122);
        chk("sticky_ovf", {15'h0, stack_ovf}, 16'h1);
        chk("sticky_unf", {15'h0, stack_unf}, 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
